// File: rtl/dmem_pkg.sv
// Shared types and constants for the LEGv8 multi-cycle data-memory responder.
package dmem_pkg;
    localparam int WORD_W       = 64;
    localparam int ADDR_W       = 64;
    localparam int DMEM_DEPTH   = 256;
    localparam int DMEM_LATENCY = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_e;
endpackage

// File: rtl/dmem_array.sv
// DEPTH x 64-bit storage: synchronous write, registered read, async active-low clear.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH = DMEM_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     we,
    input  logic                     re,
    input  logic                     rd_zero,
    input  logic [$clog2(DEPTH)-1:0] idx,
    input  logic [WORD_W-1:0]        wdata,
    output logic [WORD_W-1:0]        rdata
);
    logic [WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            rdata <= '0;
        end else begin
            if (we) mem[idx] <= wdata;
            // rd_zero forces a clean zero for rejected loads instead of stale memory
            if (re) rdata <= rd_zero ? '0 : mem[idx];
        end
    end
endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data-memory responder with fixed LATENCY and a one-cycle response pulse.
// Optional misalignment checking is built when DMEM_ALIGN_CHECK_EN is defined.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH   = DMEM_DEPTH,
    parameter int LATENCY = DMEM_LATENCY
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [WORD_W-1:0] rsp_rdata,
    output logic              rsp_error
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(LATENCY - 1);

    dmem_state_e       state, nxt;
    logic [CNT_W-1:0]  cnt;
    logic              pend;
    logic              wr_q;
    logic [IDX_W-1:0]  idx_q;
    logic [WORD_W-1:0] wdata_q;
    logic              err_q;
    logic              accept, access;
    logic              unused_addr;

    assign req_ready   = (state != WAIT);
    assign accept      = req_valid & req_ready;
    // the access fires when the captured request's countdown has expired
    assign access      = pend & (cnt == '0);
    assign unused_addr = ^{req_addr[ADDR_W-1:3+IDX_W], req_addr[2:0]};

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (accept) nxt = (LATENCY == 1) ? RESP : WAIT;
            WAIT:    if (cnt == '0) nxt = RESP;
            // with LATENCY=1 RESP also covers the cycle before the pending access
            RESP:    if (accept)    nxt = (LATENCY == 1) ? RESP : WAIT;
                     else if (pend) nxt = RESP;
                     else           nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            pend      <= 1'b0;
            wr_q      <= 1'b0;
            idx_q     <= '0;
            wdata_q   <= '0;
            rsp_valid <= 1'b0;
        end else begin
            state     <= nxt;
            rsp_valid <= access;
            if (accept) begin
                wr_q    <= req_write;
                idx_q   <= req_addr[3 +: IDX_W];
                wdata_q <= req_wdata;
                cnt     <= LAT_M1;
                pend    <= 1'b1;
            end else if (access) begin
                pend <= 1'b0;
            end else if (pend) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

`ifdef DMEM_ALIGN_CHECK_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q     <= 1'b0;
            rsp_error <= 1'b0;
        end else begin
            if (accept) err_q <= |req_addr[2:0];
            rsp_error <= access & err_q;
        end
    end
`else
    assign err_q     = 1'b0;
    assign rsp_error = 1'b0;
`endif

    dmem_array #(.DEPTH(DEPTH)) u_array (
        .clk     (clk),
        .reset   (reset),
        .we      (access & wr_q & ~err_q),
        .re      (access & ~wr_q),
        .rd_zero (err_q),
        .idx     (idx_q),
        .wdata   (wdata_q),
        .rdata   (rsp_rdata)
    );
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: LATENCY=2 instance for the main sequence,
// LATENCY=1 instance for the streaming case.
module tb_dmem_responder;
    logic        clk = 1'b0;
    logic        reset = 1'b0;

    logic        a_req_valid = 1'b0, a_req_write = 1'b0;
    logic [63:0] a_req_addr = '0, a_req_wdata = '0;
    logic        a_req_ready, a_rsp_valid, a_rsp_error;
    logic [63:0] a_rsp_rdata;

    logic        b_req_valid = 1'b0, b_req_write = 1'b0;
    logic [63:0] b_req_addr = '0, b_req_wdata = '0;
    logic        b_req_ready, b_rsp_valid, b_rsp_error;
    logic [63:0] b_rsp_rdata;

    int ncmp = 0;
    int nfail = 0;
    logic [63:0] last_rd = '0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(256), .LATENCY(2)) u_dut (
        .clk(clk), .reset(reset),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_write(a_req_write),
        .req_addr(a_req_addr), .req_wdata(a_req_wdata),
        .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata), .rsp_error(a_rsp_error)
    );

    dmem_responder #(.DEPTH(256), .LATENCY(1)) u_dut1 (
        .clk(clk), .reset(reset),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata),
        .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .rsp_error(b_rsp_error)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // one isolated LATENCY=2 transaction on u_dut with full cycle-by-cycle checks
    task automatic xact(input string tag, input logic w, input logic [63:0] a,
                        input logic [63:0] d, input logic [63:0] exp_rd, input logic exp_err);
        chk({tag, "_rdy_pre"}, 64'(a_req_ready), 64'd1);
        a_req_valid = 1'b1; a_req_write = w; a_req_addr = a; a_req_wdata = d;
        step();
        a_req_valid = 1'b0; a_req_write = 1'b0; a_req_addr = '0; a_req_wdata = '0;
        chk({tag, "_rdy_w0"}, 64'(a_req_ready), 64'd0);
        chk({tag, "_vld_w0"}, 64'(a_rsp_valid), 64'd0);
        step();
        chk({tag, "_vld_w1"}, 64'(a_rsp_valid), 64'd0);
        step();
        chk({tag, "_vld"},  64'(a_rsp_valid), 64'd1);
        chk({tag, "_rdy"},  64'(a_req_ready), 64'd1);
        chk({tag, "_rd"},   a_rsp_rdata, exp_rd);
        chk({tag, "_err"},  64'(a_rsp_error), 64'(exp_err));
        last_rd = exp_rd;
        step();
        chk({tag, "_vld_end"}, 64'(a_rsp_valid), 64'd0);
    endtask

    initial begin
        logic        w1 [6];
        logic [63:0] ad1 [6];
        logic [63:0] wd1 [6];
        logic [63:0] ex1 [6];
        logic        mis_err;
        logic [63:0] mis_rd13, mis_rd10;

        // reset state
        #2;
        chk("rst_ready", 64'(a_req_ready), 64'd1);
        chk("rst_valid", 64'(a_rsp_valid), 64'd0);
        chk("rst_rdata", a_rsp_rdata, 64'd0);
        chk("rst_error", 64'(a_rsp_error), 64'd0);
        step();
        reset = 1'b1;
        step();

        // basic store then load
        xact("st10", 1'b1, 64'h10, 64'hDEAD_BEEF_0000_0001, 64'd0, 1'b0);
        xact("ld10", 1'b0, 64'h10, 64'd0, 64'hDEAD_BEEF_0000_0001, 1'b0);

        // back-to-back: load accepted in the store's RESP cycle
        chk("b2b_rdy_pre", 64'(a_req_ready), 64'd1);
        a_req_valid = 1'b1; a_req_write = 1'b1; a_req_addr = 64'h08; a_req_wdata = 64'h55;
        step();
        a_req_valid = 1'b0;
        chk("b2b_st_rdy_w0", 64'(a_req_ready), 64'd0);
        step();
        chk("b2b_st_rdy_w1", 64'(a_req_ready), 64'd0);
        step();
        chk("b2b_st_vld", 64'(a_rsp_valid), 64'd1);
        chk("b2b_st_rdy", 64'(a_req_ready), 64'd1);
        chk("b2b_st_rd",  a_rsp_rdata, 64'hDEAD_BEEF_0000_0001);
        a_req_valid = 1'b1; a_req_write = 1'b0; a_req_addr = 64'h08; a_req_wdata = '0;
        step();
        a_req_valid = 1'b0; a_req_addr = '0;
        chk("b2b_ld_vld_w0", 64'(a_rsp_valid), 64'd0);
        chk("b2b_ld_rdy_w0", 64'(a_req_ready), 64'd0);
        step();
        chk("b2b_ld_rdy_w1", 64'(a_req_ready), 64'd0);
        step();
        chk("b2b_ld_vld", 64'(a_rsp_valid), 64'd1);
        chk("b2b_ld_rd",  a_rsp_rdata, 64'h55);
        step();
        chk("b2b_ld_vld_end", 64'(a_rsp_valid), 64'd0);

        // index wraps modulo DEPTH: 0x800 -> word 256 -> word 0
        xact("st800", 1'b1, 64'h800, 64'h7, 64'h55, 1'b0);
        xact("ld0",   1'b0, 64'h0,   64'd0, 64'h7,  1'b0);

        // reset while a store sits in WAIT
        a_req_valid = 1'b1; a_req_write = 1'b1; a_req_addr = 64'h20; a_req_wdata = 64'h1234;
        step();
        a_req_valid = 1'b0; a_req_write = 1'b0; a_req_addr = '0; a_req_wdata = '0;
        chk("mr_rdy_wait", 64'(a_req_ready), 64'd0);
        reset = 1'b0;
        #1;
        chk("mr_vld_rst", 64'(a_rsp_valid), 64'd0);
        chk("mr_rd_rst",  a_rsp_rdata, 64'd0);
        chk("mr_rdy_rst", 64'(a_req_ready), 64'd1);
        step();
        reset = 1'b1;
        chk("mr_vld_a", 64'(a_rsp_valid), 64'd0);
        step();
        chk("mr_vld_b", 64'(a_rsp_valid), 64'd0);
        step();
        chk("mr_vld_c", 64'(a_rsp_valid), 64'd0);
        xact("ld20", 1'b0, 64'h20, 64'd0, 64'd0, 1'b0);
        xact("ld10_clr", 1'b0, 64'h10, 64'd0, 64'd0, 1'b0);

        // misaligned accesses
`ifdef DMEM_ALIGN_CHECK_EN
        mis_err = 1'b1; mis_rd13 = 64'd0;  mis_rd10 = 64'h99;
`else
        mis_err = 1'b0; mis_rd13 = 64'hAB; mis_rd10 = 64'hAB;
`endif
        xact("st10b", 1'b1, 64'h10, 64'h99, last_rd, 1'b0);
        xact("st13",  1'b1, 64'h13, 64'hAB, last_rd, mis_err);
        xact("ld13",  1'b0, 64'h13, 64'd0,  mis_rd13, mis_err);
        xact("ld10c", 1'b0, 64'h10, 64'd0,  mis_rd10, 1'b0);

        // LATENCY=1 continuous stream: 2 stores then 4 loads, no gaps
        w1  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        ad1 = '{64'h0, 64'h8, 64'h0, 64'h8, 64'h800, 64'h8};
        wd1 = '{64'hA1A1, 64'hB2B2, 64'd0, 64'd0, 64'd0, 64'd0};
        ex1 = '{64'd0, 64'd0, 64'hA1A1, 64'hB2B2, 64'hA1A1, 64'hB2B2};
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("l1_rdy_%0d", i), 64'(b_req_ready), 64'd1);
            b_req_valid = 1'b1; b_req_write = w1[i]; b_req_addr = ad1[i]; b_req_wdata = wd1[i];
            step();
            if (i == 0) begin
                chk("l1_vld_0", 64'(b_rsp_valid), 64'd0);
            end else begin
                chk($sformatf("l1_vld_%0d", i), 64'(b_rsp_valid), 64'd1);
                chk($sformatf("l1_rd_%0d", i), b_rsp_rdata, ex1[i-1]);
            end
        end
        b_req_valid = 1'b0; b_req_write = 1'b0; b_req_addr = '0; b_req_wdata = '0;
        step();
        chk("l1_vld_last", 64'(b_rsp_valid), 64'd1);
        chk("l1_rd_last",  b_rsp_rdata, ex1[5]);
        chk("l1_err_last", 64'(b_rsp_error), 64'd0);
        step();
        chk("l1_vld_end", 64'(b_rsp_valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
# dmem_responder

Multi-cycle data-memory responder for the LEGv8 pipeline: it serves LDUR/STUR requests issued by the MEM stage over a valid/ready request channel and returns a one-cycle response pulse after a fixed, parameterised latency. It replaces the single-cycle data memory as the target of MEM-stage accesses. The hazard logic stalls the pipeline while `req_ready` is low or a response is pending.

## Interface
- `DEPTH`, 256: number of 64-bit words; must be a power of two ≥ 2.
- `LATENCY`, 2: cycles from request acceptance to response; must be ≥ 1.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-low reset (asserts immediately when low, released synchronously by the environment).
- `req_valid`  in  1: request present.
- `req_ready`  out  1: responder can accept a request this cycle.
- `req_write`  in  1: 1 = STUR (store), 0 = LDUR (load).
- `req_addr`  in  64: byte address (ALU result).
- `req_wdata`  in  64: store data.
- `rsp_valid`  out  1: one-cycle response pulse.
- `rsp_rdata`  out  64: load data; holds the value from the last load response.
- `rsp_error`  out  1: misaligned-access flag, qualified by `rsp_valid`.

## Operation
- FSM states: IDLE, WAIT, RESP.
- `req_ready` = 1 in IDLE and RESP, 0 in WAIT. It is a combinational decode of the state.
- Accept = `req_valid & req_ready` at a rising edge:
  - capture `req_write`, `req_addr`, `req_wdata`;
  - load the countdown with `LATENCY-1`;
  - go to WAIT, or straight to RESP when `LATENCY` = 1.
- WAIT: decrement each cycle; at count 0 the next edge enters RESP and performs the access.
  - Store: write the array word.
  - Load: register the array word into `rsp_rdata`.
- RESP lasts one cycle with `rsp_valid` = 1.
  - An accept in RESP restarts the sequence with no idle cycle; otherwise return to IDLE.
  - Peak throughput is one request per `LATENCY` cycles.
- Word index = `req_addr[3 +: log2(DEPTH)]`. Higher address bits are ignored, so the index wraps modulo `DEPTH`.
- `req_addr[2:0]` is ignored unless `DMEM_ALIGN_CHECK_EN` is defined.
- Stores never change `rsp_rdata`.
- There is no response backpressure: the MEM/WB register always consumes the pulse.
- `req_*` inputs are ignored when `req_ready` = 0; no request is queued.

## Timing
- Reset (`reset` low):
  - state = IDLE, so `req_ready` = 1 once reset is released;
  - `rsp_valid` = 0, `rsp_rdata` = 0, `rsp_error` = 0;
  - countdown = 0; all array words cleared to 0.
- Accept at edge N → `rsp_valid` high during cycle N+`LATENCY`, i.e. after edge N+`LATENCY`.
- A store is committed at edge N+`LATENCY`.
  - A load accepted in that store's RESP cycle sees the new data.
- Reset mid-operation drops the pending request: no store commit, no response.
- Simultaneous accept and response in RESP: the old response is emitted and the new request is captured in the same cycle.

## Configuration
- Macro: `DMEM_ALIGN_CHECK_EN`.
- Defined: `req_addr[2:0]` ≠ 0 is captured as an error.
  - Response has `rsp_error` = 1.
  - A store is suppressed (array unchanged).
  - A load returns `rsp_rdata` = 0.
  - Latency is unchanged.
- Undefined: `rsp_error` is tied to 0, low address bits are ignored, and no error logic is built.

## Structure
- Shared package `dmem_pkg`:
  - state enum (IDLE/WAIT/RESP);
  - `WORD_W` = 64, `ADDR_W` = 64;
  - default `DEPTH` and `LATENCY` constants.
- One sub-module, `dmem_array`: `DEPTH`×64 storage with synchronous write, registered read and async-low clear.
  - The FSM, countdown and error logic stay in `dmem_responder`.

## Test plan
- Reset, then store 0xDEAD_BEEF_0000_0001 at address 0x10, then load 0x10 with `LATENCY` = 2 → `rsp_valid` pulses 2 cycles after each accept; load `rsp_rdata` = 0xDEAD_BEEF_0000_0001.
- Back-to-back: store 0x55 at 0x08, then a load of 0x08 accepted in the store's RESP cycle → load returns 0x55; `req_ready` is 0 only during WAIT.
- Wrap-around with `DEPTH` = 256: store 0x7 at 0x800, then load 0x0 → returns 0x7.
- Assert `reset` low while a store to 0x20 is in WAIT → no `rsp_valid`; a later load of 0x20 returns 0.
- With `DMEM_ALIGN_CHECK_EN`: store to 0x13 → `rsp_error` = 1 and memory unchanged; a load of 0x13 returns `rsp_rdata` = 0 with `rsp_error` = 1. Without the macro: a load of 0x13 returns the word at 0x10 with `rsp_error` = 0.
- `LATENCY` = 1: a continuous `req_valid` stream of 4 loads → 4 consecutive `rsp_valid` cycles, each one cycle after its accept.
